dram_rmw_unit: RTL and testbench
================================

DRAM_RMW_UNIT -- requirements
Module: dram_rmw_unit

Interface
REQ-001 Parameter DATA_W, default `data_size (32), data word width.
REQ-002 Parameter ADDR_W, default 9, word address width.
REQ-003 clk  in  1  single clock; all state changes on rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 req_re  in  1  load request from dram_controller.
REQ-006 req_we  in  1  store request from dram_controller.
REQ-007 req_addr  in  ADDR_W  word address.
REQ-008 req_off  in  2  byte offset within word.
REQ-009 req_wdata  in  DATA_W  store data; sb/sh data is right-aligned (bits [7:0] / [15:0]).
REQ-010 req_stype  in  store_conf  store type: sb_conf, sh_conf, sw_conf.
REQ-011 busy  out  1  high while a request is in flight.
REQ-012 rd_valid  out  1  one-cycle pulse; rd_word is valid.
REQ-013 rd_word  out  DATA_W  loaded word, addressed lane shifted to bit 0 (feeds dmem_word).
REQ-014 misalign_err  out  1  one-cycle pulse on a rejected misaligned request.
REQ-015 ram_addr  out  ADDR_W  RAM address.
REQ-016 ram_re / ram_we  out  1 each  RAM read / write strobes.
REQ-017 ram_wdata  out  DATA_W  full word written to RAM.
REQ-018 ram_rdata  in  DATA_W  RAM read data, valid exactly one cycle after ram_re.

Function
REQ-019 The FSM SHALL use states IDLE, LD_RD, LD_CAP, ST_WR, RMW_RD, RMW_MRG, RMW_WR.
REQ-020 A request SHALL be accepted only in IDLE; addr, off, wdata and stype are registered at acceptance; request inputs are ignored while busy.
REQ-021 If req_we and req_re are both high in IDLE, the write SHALL be taken and the read dropped.
REQ-022 busy SHALL be high in every state except IDLE.
REQ-023 Misalignment: sh with req_off[0]=1, sw with req_off!=0, or load with req_off!=0 while req_stype=sw_conf SHALL NOT be accepted. misalign_err SHALL pulse the following cycle, the FSM stays in IDLE, and no RAM access occurs.
REQ-024 Load: IDLE -> LD_RD (ram_re=1, ram_addr=latched addr) -> LD_CAP (rd_word <= ram_rdata >> 8*off, rd_valid=1 next cycle) -> IDLE. rd_valid rises 3 cycles after acceptance.
REQ-025 rd_word SHALL hold its value until the next load capture.
REQ-026 sw: IDLE -> ST_WR (ram_we=1, ram_wdata=latched wdata) -> IDLE. 1-cycle write latency after acceptance.
REQ-027 sb/sh: IDLE -> RMW_RD (ram_re=1) -> RMW_MRG (register the merged word from ram_rdata) -> RMW_WR (ram_we=1, ram_wdata=merged word) -> IDLE.
REQ-028 sb merge: byte lane off (bits 8*off+7 : 8*off) replaced by wdata[7:0]; all other bits preserved.
REQ-029 sh merge: half lane off[1] (bits 16*off[1]+15 : 16*off[1]) replaced by wdata[15:0]; all other bits preserved.
REQ-030 ram_re and ram_we SHALL never be high together, and each SHALL be high for exactly one cycle per access.
REQ-031 ram_addr SHALL equal the latched address in every non-IDLE state, and 0 in IDLE.
REQ-032 rd_valid and misalign_err SHALL never be high in the same cycle.

Reset
REQ-033 While rst is high, ram_re and ram_we SHALL be forced to 0 combinationally, so no RAM access occurs in the reset cycle.
REQ-034 On a clock edge with rst high: state=IDLE, busy=0, rd_valid=0, misalign_err=0, rd_word=0; all latched request fields cleared.
REQ-035 Reset mid-RMW SHALL abandon the operation with no RAM write; RAM contents are unchanged.

Verification
REQ-036 RAM[5]=0x11223344; sb addr=5 off=2 wdata=0xAB -> ram_we exactly 3 cycles after acceptance, ram_wdata=0x11AB3344.
REQ-037 RAM[7]=0xDEADBEEF; load addr=7 off=2 -> rd_valid pulse 3 cycles after acceptance, rd_word=0x0000DEAD.
REQ-038 sh off=1 -> misalign_err pulse, busy stays 0, no ram_re/ram_we.
REQ-039 Back-to-back sw then load to the same address, each issued on the first IDLE cycle -> load returns the stored word; requests raised while busy are ignored.
REQ-040 rst asserted in RMW_MRG -> no ram_we ever occurs for that store; next cycle busy=0, state IDLE.
REQ-041 req_re and req_we both high with sw, off=0 -> only the write occurs; no rd_valid.

Source files
------------

// File: rtl/dram_rmw_unit_if.sv
// Request/response and RAM-side signal bundle for dram_rmw_unit.
// master = controller plus RAM model, slave = the RMW unit.
interface dram_rmw_unit_if #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 9
);
   // Request side
   logic              req_re;
   logic              req_we;
   logic [ADDR_W-1:0] req_addr;
   logic [1:0]        req_off;
   logic [DATA_W-1:0] req_wdata;
   logic [1:0]        req_stype;

   // Response side
   logic              busy;
   logic              rd_valid;
   logic [DATA_W-1:0] rd_word;
   logic              misalign_err;

   // RAM side
   logic [ADDR_W-1:0] ram_addr;
   logic              ram_re;
   logic              ram_we;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_rdata;

   modport master (
      output req_re, req_we, req_addr, req_off, req_wdata, req_stype, ram_rdata,
      input  busy, rd_valid, rd_word, misalign_err, ram_addr, ram_re, ram_we, ram_wdata
   );

   modport slave (
      input  req_re, req_we, req_addr, req_off, req_wdata, req_stype, ram_rdata,
      output busy, rd_valid, rd_word, misalign_err, ram_addr, ram_re, ram_we, ram_wdata
   );
endinterface

// File: rtl/dram_rmw_unit.sv
// Byte/half/word load-store front end for a word-wide single-port RAM.
// Sub-word stores are done as read-modify-write; loads return the word shifted to the lane.
module dram_rmw_unit #(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned ADDR_W = 9
) (
   input  logic              clk,
   input  logic              rst,
   dram_rmw_unit_if.slave    bus
);

   localparam logic [1:0] StypeSb = 2'd0;
   localparam logic [1:0] StypeSh = 2'd1;

   typedef enum logic [2:0] {
      StIdle,
      StLdRd,
      StLdCap,
      StStWr,
      StRmwRd,
      StRmwMrg,
      StRmwWr
   } state_e;

   state_e            state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [1:0]        off_q, off_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic [1:0]        stype_q, stype_d;
   logic [DATA_W-1:0] rd_word_q, rd_word_d;
   logic              rd_valid_q, rd_valid_d;
   logic              mis_err_q, mis_err_d;

   logic              req_sb, req_sh, req_sw;
   logic              st_misalign, ld_misalign;
   logic [DATA_W-1:0] lane_mask, lane_data, merged;

   // Any stype other than sb/sh is handled as a full-word access.
   always_comb begin
      req_sb      = (bus.req_stype == StypeSb);
      req_sh      = (bus.req_stype == StypeSh);
      req_sw      = !(req_sb || req_sh);
      st_misalign = (req_sh && bus.req_off[0]) || (req_sw && (bus.req_off != 2'd0));
      ld_misalign = req_sw && (bus.req_off != 2'd0);
   end

   always_comb begin
      lane_mask = '0;
      lane_data = '0;
      if (stype_q == StypeSb) begin
         lane_mask = DATA_W'(8'hFF) << {off_q, 3'b000};
         lane_data = DATA_W'(wdata_q[7:0]) << {off_q, 3'b000};
      end else begin
         lane_mask = DATA_W'(16'hFFFF) << {off_q[1], 4'b0000};
         lane_data = DATA_W'(wdata_q[15:0]) << {off_q[1], 4'b0000};
      end
      merged = (bus.ram_rdata & ~lane_mask) | (lane_data & lane_mask);
   end

   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      off_d      = off_q;
      wdata_d    = wdata_q;
      stype_d    = stype_q;
      rd_word_d  = rd_word_q;
      rd_valid_d = 1'b0;
      mis_err_d  = 1'b0;

      unique case (state_q)
         StIdle: begin
            // A store wins over a simultaneous load.
            if (bus.req_we) begin
               if (st_misalign) begin
                  mis_err_d = 1'b1;
               end else begin
                  addr_d  = bus.req_addr;
                  off_d   = bus.req_off;
                  wdata_d = bus.req_wdata;
                  stype_d = bus.req_stype;
                  state_d = req_sw ? StStWr : StRmwRd;
               end
            end else if (bus.req_re) begin
               if (ld_misalign) begin
                  mis_err_d = 1'b1;
               end else begin
                  addr_d  = bus.req_addr;
                  off_d   = bus.req_off;
                  wdata_d = bus.req_wdata;
                  stype_d = bus.req_stype;
                  state_d = StLdRd;
               end
            end
         end
         StLdRd:  state_d = StLdCap;
         StLdCap: begin
            rd_word_d  = bus.ram_rdata >> {off_q, 3'b000};
            rd_valid_d = 1'b1;
            state_d    = StIdle;
         end
         StStWr:  state_d = StIdle;
         StRmwRd: state_d = StRmwMrg;
         StRmwMrg: begin
            // The store data register is reused to hold the merged word.
            wdata_d = merged;
            state_d = StRmwWr;
         end
         StRmwWr: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= StIdle;
         addr_q     <= '0;
         off_q      <= '0;
         wdata_q    <= '0;
         stype_q    <= '0;
         rd_word_q  <= '0;
         rd_valid_q <= 1'b0;
         mis_err_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         addr_q     <= addr_d;
         off_q      <= off_d;
         wdata_q    <= wdata_d;
         stype_q    <= stype_d;
         rd_word_q  <= rd_word_d;
         rd_valid_q <= rd_valid_d;
         mis_err_q  <= mis_err_d;
      end
   end

   // RAM strobes are gated by rst so an abandoned RMW never writes.
   always_comb begin
      bus.busy         = (state_q != StIdle);
      bus.ram_addr     = (state_q != StIdle) ? addr_q : '0;
      bus.ram_re       = !rst && ((state_q == StLdRd) || (state_q == StRmwRd));
      bus.ram_we       = !rst && ((state_q == StStWr) || (state_q == StRmwWr));
      bus.ram_wdata    = ((state_q == StStWr) || (state_q == StRmwWr)) ? wdata_q : '0;
      bus.rd_valid     = rd_valid_q;
      bus.rd_word      = rd_word_q;
      bus.misalign_err = mis_err_q;
   end

   a_ram_excl: assert property (@(posedge clk) disable iff (rst) !(bus.ram_re && bus.ram_we));
   a_resp_excl: assert property (@(posedge clk) disable iff (rst)
                                 !(bus.rd_valid && bus.misalign_err));

endmodule

// File: tb/tb_dram_rmw_unit.sv
// Scoreboard bench for dram_rmw_unit: stimulus pushes expected events from a
// word-array reference model, a negedge monitor pops and compares them.
module tb_dram_rmw_unit;

   localparam logic [1:0] SB = 2'd0;
   localparam logic [1:0] SH = 2'd1;
   localparam logic [1:0] SW = 2'd2;
   localparam int KRd  = 0;
   localparam int KWr  = 1;
   localparam int KErr = 2;

   typedef struct {
      int          kind;
      int          cyc;
      logic [8:0]  addr;
      logic [31:0] data;
   } ev_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rst_d1 = 1'b1;
   int   cyc = 0;
   int   tests = 0;
   int   fails = 0;

   ev_t         exp_q[$];
   logic [31:0] ref_mem [512];
   logic [31:0] mem [512];
   logic [31:0] exp_hold = '0;
   int          exp_start = 1;
   int          exp_end = 0;
   int          exp_re_cyc = -1;
   logic [8:0]  exp_addr = '0;

   logic        pl_en = 1'b0;
   logic [8:0]  pl_addr = '0;
   logic [31:0] pl_data = '0;

   dram_rmw_unit_if #(.DATA_W(32), .ADDR_W(9)) bus ();

   dram_rmw_unit #(.DATA_W(32), .ADDR_W(9)) u_dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc    <= cyc + 1;
      rst_d1 <= rst;
   end

   // RAM model: read data valid one cycle after ram_re.
   initial bus.ram_rdata = '0;
   always @(posedge clk) begin
      if (pl_en) mem[pl_addr] <= pl_data;
      else if (bus.ram_we) mem[bus.ram_addr] <= bus.ram_wdata;
      if (bus.ram_re) bus.ram_rdata <= mem[bus.ram_addr];
   end

   function automatic string kname(input int k);
      if (k == KRd) return "rd_valid";
      if (k == KWr) return "ram_we";
      return "misalign_err";
   endfunction

   // Monitor: pops expected events and checks per-cycle rules.
   always @(negedge clk) begin
      ev_t         e;
      int          got_kind;
      logic [31:0] got_data;
      logic        busy_exp;
      logic        bad;
      if (cyc >= 1) begin
         if (rst_d1) exp_hold = '0;
         while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            tests++;
            fails++;
            $display("FAIL missed_%s: nothing seen by cycle %0d, expected at cycle %0d",
                     kname(exp_q[0].kind), cyc, exp_q[0].cyc);
            e = exp_q.pop_front();
         end
         if (bus.ram_we || bus.rd_valid || bus.misalign_err) begin
            got_kind = bus.ram_we ? KWr : (bus.rd_valid ? KRd : KErr);
            got_data = bus.ram_we ? bus.ram_wdata : (bus.rd_valid ? bus.rd_word : 32'h0);
            tests++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_%s: cycle %0d addr %0d data %h, expected no output",
                        kname(got_kind), cyc, bus.ram_addr, got_data);
            end else begin
               e = exp_q.pop_front();
               if (e.kind == KRd) exp_hold = e.data;
               if (e.kind != got_kind || e.cyc != cyc ||
                   (got_kind != KErr && e.data != got_data) ||
                   (got_kind == KWr && e.addr != bus.ram_addr)) begin
                  fails++;
                  $display("FAIL event: got %s cyc %0d addr %0d data %h, expected %s cyc %0d addr %0d data %h",
                           kname(got_kind), cyc, bus.ram_addr, got_data,
                           kname(e.kind), e.cyc, e.addr, e.data);
               end
            end
         end
         busy_exp = (cyc >= exp_start) && (cyc <= exp_end);
         bad = 1'b0;
         if (bus.ram_re && bus.ram_we) begin
            bad = 1'b1;
            $display("FAIL ram_excl: cycle %0d got re=1 we=1, expected not both", cyc);
         end
         if (bus.rd_valid && bus.misalign_err) begin
            bad = 1'b1;
            $display("FAIL resp_excl: cycle %0d got rd_valid=1 misalign_err=1, expected not both", cyc);
         end
         if (bus.busy !== busy_exp) begin
            bad = 1'b1;
            $display("FAIL busy: cycle %0d got %b, expected %b", cyc, bus.busy, busy_exp);
         end
         if (bus.ram_re !== (cyc == exp_re_cyc && !rst)) begin
            bad = 1'b1;
            $display("FAIL ram_re: cycle %0d got %b, expected %b", cyc, bus.ram_re,
                     (cyc == exp_re_cyc && !rst));
         end
         if (bus.ram_addr !== (busy_exp ? exp_addr : 9'd0)) begin
            bad = 1'b1;
            $display("FAIL ram_addr: cycle %0d got %0d, expected %0d", cyc, bus.ram_addr,
                     busy_exp ? exp_addr : 9'd0);
         end
         if (bus.rd_word !== exp_hold) begin
            bad = 1'b1;
            $display("FAIL rd_word_hold: cycle %0d got %h, expected %h", cyc, bus.rd_word, exp_hold);
         end
         tests++;
         if (bad) fails++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      bus.req_re    = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_off   = '0;
      bus.req_wdata = '0;
      bus.req_stype = SW;
   endtask

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", name, got, exp);
      end
   endtask

   task automatic preload(input logic [8:0] a, input logic [31:0] d);
      pl_en   = 1'b1;
      pl_addr = a;
      pl_data = d;
      ref_mem[a] = d;
      step();
      pl_en = 1'b0;
   endtask

   // While the unit is expected busy, throw random requests at it; all must be ignored.
   task automatic wait_idle();
      while (cyc <= exp_end) begin
         if ($urandom_range(0, 1) == 1) begin
            bus.req_re    = 1'($urandom);
            bus.req_we    = 1'($urandom);
            bus.req_addr  = 9'($urandom);
            bus.req_off   = 2'($urandom);
            bus.req_wdata = $urandom;
            bus.req_stype = 2'($urandom);
         end else begin
            drive_idle();
         end
         step();
      end
   endtask

   task automatic issue(input logic re, input logic we, input logic [8:0] addr,
                        input logic [1:0] off, input logic [31:0] wd, input logic [1:0] st,
                        input bit abort);
      int          acc;
      bit          mis;
      logic [31:0] m;
      ev_t         e;
      wait_idle();
      bus.req_re    = re;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_off   = off;
      bus.req_wdata = wd;
      bus.req_stype = st;
      acc = cyc;
      if (we) mis = (st == SH && off[0]) || (st == SW && off != 2'd0);
      else    mis = (st == SW && off != 2'd0);
      e.addr = addr;
      exp_addr  = addr;
      exp_start = acc + 1;
      exp_re_cyc = -1;
      if (mis) begin
         exp_end = acc;
         e.kind = KErr; e.cyc = acc + 1; e.data = '0;
         exp_q.push_back(e);
      end else if (we && st == SW) begin
         exp_end = acc + 1;
         ref_mem[addr] = wd;
         e.kind = KWr; e.cyc = acc + 1; e.data = wd;
         exp_q.push_back(e);
      end else if (we) begin
         exp_re_cyc = acc + 1;
         m = ref_mem[addr];
         for (int b = 0; b < 4; b++) begin
            if (st == SB && b == int'(off)) m[8*b +: 8] = wd[7:0];
            if (st == SH && (b / 2) == int'(off[1])) m[8*b +: 8] = wd[8*(b%2) +: 8];
         end
         if (abort) begin
            exp_end = acc + 2;
         end else begin
            exp_end = acc + 3;
            ref_mem[addr] = m;
            e.kind = KWr; e.cyc = acc + 3; e.data = m;
            exp_q.push_back(e);
         end
      end else begin
         exp_re_cyc = acc + 1;
         exp_end = acc + 2;
         e.kind = KRd; e.cyc = acc + 3; e.data = ref_mem[addr] >> (8 * int'(off));
         exp_q.push_back(e);
      end
      step();
      drive_idle();
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] r;
      drive_idle();
      rst = 1'b1;
      step();
      for (int a = 0; a < 16; a++) preload(9'(a), $urandom);
      preload(9'd5, 32'h11223344);
      preload(9'd7, 32'hDEADBEEF);
      chk("reset_busy", 32'(bus.busy), 32'h0);
      chk("reset_rd_valid", 32'(bus.rd_valid), 32'h0);
      chk("reset_misalign_err", 32'(bus.misalign_err), 32'h0);
      chk("reset_rd_word", bus.rd_word, 32'h0);
      chk("reset_ram_strobes", {30'h0, bus.ram_re, bus.ram_we}, 32'h0);
      chk("reset_ram_addr", 32'(bus.ram_addr), 32'h0);
      rst = 1'b0;
      step();

      issue(1'b0, 1'b1, 9'd5, 2'd2, 32'h000000AB, SB, 1'b0);
      issue(1'b1, 1'b0, 9'd7, 2'd2, 32'h0, SB, 1'b0);
      issue(1'b1, 1'b0, 9'd5, 2'd0, 32'h0, SW, 1'b0);
      issue(1'b0, 1'b1, 9'd3, 2'd1, 32'h00001234, SH, 1'b0);
      issue(1'b1, 1'b0, 9'd4, 2'd1, 32'h0, SW, 1'b0);
      issue(1'b0, 1'b1, 9'd9, 2'd0, 32'hCAFEF00D, SW, 1'b0);
      issue(1'b1, 1'b0, 9'd9, 2'd0, 32'h0, SW, 1'b0);
      issue(1'b0, 1'b1, 9'd12, 2'd2, 32'h00005566, SH, 1'b0);
      issue(1'b1, 1'b0, 9'd12, 2'd0, 32'h0, SW, 1'b0);
      issue(1'b1, 1'b1, 9'd11, 2'd0, 32'h0BADBEEF, SW, 1'b0);
      issue(1'b1, 1'b0, 9'd11, 2'd1, 32'h0, SH, 1'b0);

      // Reset while the merged word sits in RMW_MRG: the store must vanish.
      issue(1'b0, 1'b1, 9'd5, 2'd1, 32'h00000077, SB, 1'b1);
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      issue(1'b1, 1'b0, 9'd5, 2'd0, 32'h0, SW, 1'b0);

      for (int n = 0; n < 400; n++) begin
         r = $urandom_range(0, 9);
         issue(r < 4 || r == 9, r >= 4, 9'($urandom_range(0, 15)), 2'($urandom),
               $urandom, 2'($urandom_range(0, 2)), 1'b0);
         if ($urandom_range(0, 7) == 0) begin
            repeat ($urandom_range(1, 3)) begin
               wait_idle();
               drive_idle();
               step();
            end
         end
      end

      wait_idle();
      drive_idle();
      repeat (8) step();
      chk("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
